// File: rtl/serial_add.sv
// Bit-serial adder: accepts two WIDTH-bit operands plus carry-in, adds them LSB-first
// through a 1-bit add cell over WIDTH clocks, and presents sum, carry-out and signed overflow.

module serial_add_cell #(
    parameter string MODEL = "Behavioral"
) (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_c,
    output logic o_co
);

    generate
        if (MODEL == "Structural") begin : g_structural
            logic w_p;
            logic w_g;
            logic w_t;
            xor u_x0 (w_p, i_a, i_b);
            xor u_x1 (o_c, w_p, i_ci);
            and u_a0 (w_g, i_a, i_b);
            and u_a1 (w_t, w_p, i_ci);
            or  u_o0 (o_co, w_g, w_t);
        end else if (MODEL == "DataFlow") begin : g_dataflow
            assign o_c  = i_a ^ i_b ^ i_ci;
            assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
        end else begin : g_behavioral
            // Any unrecognised style falls back to the behavioural description.
            always_comb begin
                {o_co, o_c} = {1'b0, i_a} + {1'b0, i_b} + {1'b0, i_ci};
            end
        end
    endgenerate

endmodule

module serial_add #(
    parameter int    WIDTH = 8,
    parameter string MODEL = "Behavioral"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             co,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic             w_cell_c;
    logic             w_cell_co;
    logic             w_last;

    serial_add_cell #(.MODEL(MODEL)) u_cell (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0]),
        .i_ci (r_carry),
        .o_c  (w_cell_c),
        .o_co (w_cell_co)
    );

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next; a missing branch would infer a latch.
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking everywhere so each register samples the pre-edge value of the others.
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= ci;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                        r_ovf    <= 1'b0;
                    end
                end
                RUN: begin
                    r_sum_sh <= {w_cell_c, r_sum_sh[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_cell_co;
                    // At the MSB, r_carry is the carry into bit WIDTH-1.
                    if (w_last) begin
                        r_ovf <= r_carry ^ w_cell_co;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign c         = out_valid ? r_sum_sh : '0;
    assign co        = out_valid & r_carry;
    assign ovf       = out_valid & r_ovf;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: directed scenarios on a WIDTH=8 instance and a
// back-to-back random sweep over WIDTH {2,8,32} x each MODEL against an arithmetic model.

module tb_serial_add;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] c;
    logic       co;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    bit sweep_go   = 1'b0;
    int sweep_done = 0;
    localparam int N_OPS = 20;

    always #5 clk = ~clk;

    serial_add #(.WIDTH(8), .MODEL("Behavioral")) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .co        (co),
        .ovf       (ovf)
    );

    // Reference: {ovf, co, c}, with ovf as the two's-complement overflow rule.
    function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic z);
        logic [8:0] s;
        logic       v;
        s = {1'b0, x} + {1'b0, y} + {8'd0, z};
        v = (x[7] == y[7]) && (s[7] != x[7]);
        return {v, s};
    endfunction

    generate
        for (genvar wi = 0; wi < 3; wi++) begin : g_w
            localparam int W = (wi == 0) ? 2 : (wi == 1) ? 8 : 32;
            for (genvar mi = 0; mi < 3; mi++) begin : g_m
                localparam string M = (mi == 0) ? "Behavioral" : (mi == 1) ? "DataFlow" : "Structural";
                logic         iv;
                logic         ir;
                logic         ov;
                logic         orr;
                logic         sci;
                logic         sco;
                logic         sovf;
                logic [W-1:0] sa;
                logic [W-1:0] sb;
                logic [W-1:0] sc;
                logic [W+1:0] exp_q[$];
                logic [W+1:0] e;
                int           cyc;
                int           got;
                int           last_out;
                bit           acc;

                serial_add #(.WIDTH(W), .MODEL(M)) u_dut (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .in_valid  (iv),
                    .in_ready  (ir),
                    .a         (sa),
                    .b         (sb),
                    .ci        (sci),
                    .out_valid (ov),
                    .out_ready (orr),
                    .c         (sc),
                    .co        (sco),
                    .ovf       (sovf)
                );

                function automatic logic [W+1:0] ref_w(input logic [W-1:0] x, input logic [W-1:0] y,
                                                       input logic z);
                    logic [W:0] s;
                    logic       v;
                    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, z};
                    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
                    return {v, s};
                endfunction

                initial begin
                    iv  = 1'b0;
                    orr = 1'b0;
                    sa  = '0;
                    sb  = '0;
                    sci = 1'b0;
                    wait (sweep_go);
                    @(posedge clk); #1;
                    iv  = 1'b1;
                    orr = 1'b1;
                    sa  = W'($urandom);
                    sb  = W'($urandom);
                    sci = 1'($urandom);
                    cyc = 0;
                    got = 0;
                    last_out = -1;
                    while (got < N_OPS && cyc < 3000) begin
                        acc = ir;
                        if (acc) exp_q.push_back(ref_w(sa, sb, sci));
                        @(posedge clk); #1;
                        cyc++;
                        if (acc) begin
                            sa  = W'($urandom);
                            sb  = W'($urandom);
                            sci = 1'($urandom);
                        end
                        if (ov) begin
                            total++;
                            if (exp_q.size() == 0) begin
                                bad++;
                                $display("FAIL sweep W=%0d %s: result with no accepted operand", W, M);
                            end else begin
                                e = exp_q.pop_front();
                                if ({sovf, sco, sc} !== e) begin
                                    bad++;
                                    $display("FAIL sweep W=%0d %s: got ovf=%b co=%b c=%h want ovf=%b co=%b c=%h",
                                             W, M, sovf, sco, sc, e[W+1], e[W], e[W-1:0]);
                                end
                            end
                            if (last_out >= 0) begin
                                total++;
                                if (cyc - last_out !== W + 2) begin
                                    bad++;
                                    $display("FAIL spacing W=%0d %s: got %0d want %0d", W, M, cyc - last_out, W + 2);
                                end
                            end
                            last_out = cyc;
                            got++;
                        end
                    end
                    total++;
                    if (got !== N_OPS) begin
                        bad++;
                        $display("FAIL sweep timeout W=%0d %s: got %0d results want %0d", W, M, got, N_OPS);
                    end
                    iv  = 1'b0;
                    orr = 1'b0;
                    sweep_done++;
                end
            end
        end
    endgenerate

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tci);
        in_valid = 1'b1;
        a  = ta;
        b  = tb;
        ci = tci;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({in_ready, out_valid, c, co, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got rdy=%b vld=%b c=%h co=%b ovf=%b want rdy=1 vld=0 c=00 co=0 ovf=0",
                     in_ready, out_valid, c, co, ovf);
        end
        release_reset();
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_op(8'h12, 8'h34, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, c} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_mid_run: got rdy=%b vld=%b c=%h want rdy=1 vld=0 c=00", in_ready, out_valid, c);
        end
        release_reset();
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(n);
        total++;
        if (n !== 8 || {ovf, co, c} !== {1'b0, 1'b0, 8'h02}) begin
            bad++;
            $display("FAIL after_reset: got lat=%0d c=%h co=%b ovf=%b want lat=8 c=02 co=0 ovf=0", n, c, co, ovf);
        end
        finish_op();
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(n);
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, c, co, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_in_done: got rdy=%b vld=%b c=%h co=%b ovf=%b want rdy=1 vld=0 c=00 co=0 ovf=0",
                     in_ready, out_valid, c, co, ovf);
        end
        release_reset();
    endtask

    task automatic test_basic();
        int n;
        start_op(8'h3C, 8'h15, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if ({in_ready, out_valid, c, co, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL basic_run_gate: got rdy=%b vld=%b c=%h co=%b ovf=%b want all 0",
                     in_ready, out_valid, c, co, ovf);
        end
        wait_done(n);
        total++;
        if (n + 3 !== 8) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 8", n + 3);
        end
        total++;
        if ({ovf, co, c} !== {1'b0, 1'b0, 8'h51}) begin
            bad++;
            $display("FAIL basic_sum: got c=%h co=%b ovf=%b want c=51 co=0 ovf=0", c, co, ovf);
        end
        finish_op();
    endtask

    task automatic test_carry_chain();
        logic [7:0] va[3]  = '{8'hFF, 8'h7F, 8'h80};
        logic [7:0] vb[3]  = '{8'h00, 8'h01, 8'h80};
        logic       vc[3]  = '{1'b1, 1'b0, 1'b0};
        logic [9:0] ve[3]  = '{{1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80}, {1'b1, 1'b1, 8'h00}};
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [9:0] exp_v;
        int         n;
        for (int i = 0; i < 9; i++) begin
            if (i < 3) begin
                ra = va[i]; rb = vb[i]; rc = vc[i]; exp_v = ve[i];
            end else begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                exp_v = ref8(ra, rb, rc);
            end
            start_op(ra, rb, rc);
            wait_done(n);
            total++;
            if (n !== 8 || {ovf, co, c} !== exp_v) begin
                bad++;
                $display("FAIL carry_chain %h+%h+%b: got lat=%0d c=%h co=%b ovf=%b want lat=8 c=%h co=%b ovf=%b",
                         ra, rb, rc, n, c, co, ovf, exp_v[7:0], exp_v[8], exp_v[9]);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ra;
        logic [7:0] rb;
        logic [9:0] exp_v;
        int         n;
        ra = 8'($urandom) | 8'h80;
        rb = 8'($urandom) | 8'h80;
        exp_v = ref8(ra, rb, 1'b1);
        start_op(ra, rb, 1'b1);
        wait_done(n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, ovf, co, c} !== {1'b1, 1'b0, exp_v}) begin
                bad++;
                $display("FAIL backpressure cycle %0d: got vld=%b rdy=%b c=%h co=%b ovf=%b want vld=1 rdy=0 c=%h co=%b ovf=%b",
                         i, out_valid, in_ready, c, co, ovf, exp_v[7:0], exp_v[8], exp_v[9]);
            end
        end
        finish_op();
        total++;
        if ({in_ready, out_valid, c} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b c=%h want rdy=1 vld=0 c=00", in_ready, out_valid, c);
        end
    endtask

    task automatic test_input_isolation();
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [9:0] exp_v;
        int         n;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        exp_v = ref8(ra, rb, rc);
        start_op(ra, rb, rc);
        n = 0;
        while (!out_valid && n < 50) begin
            in_valid = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        total++;
        if (n !== 8 || {ovf, co, c} !== exp_v) begin
            bad++;
            $display("FAIL isolation: got lat=%0d c=%h co=%b ovf=%b want lat=8 c=%h co=%b ovf=%b",
                     n, c, co, ovf, exp_v[7:0], exp_v[8], exp_v[9]);
        end
        finish_op();
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL isolation_no_second_accept: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        sweep_go = 1'b1;
        n = 0;
        while (sweep_done < 9 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sweep_done !== 9) begin
            bad++;
            $display("FAIL back_to_back_timeout: got %0d streams finished want 9", sweep_done);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a  = '0;
        b  = '0;
        ci = 1'b0;
        test_reset();
        test_reset_mid_run();
        test_basic();
        test_carry_chain();
        test_backpressure();
        test_input_isolation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
